// File: rtl/cmp_pkg.sv
// Shared definitions for the compressor frame scheduler: FSM encoding,
// encoded-length rule of the zero-skip packer, and a constant clog2 helper.
package cmp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STREAM    = 3'd1,
        FLUSH     = 3'd2,
        WAIT_DONE = 3'd3,
        REPORT    = 3'd4
    } state_t;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A zero word costs a single flag bit; a nonzero word costs the flag plus
    // the full word.
    function automatic int unsigned enc_bits(input logic [63:0] word,
                                             input int unsigned word_w);
        return (word == 64'd0) ? 32'd1 : (word_w + 32'd1);
    endfunction

endpackage

// File: rtl/cmp_frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps,
// so the most recently served requester has the lowest priority.
module rr_arbiter
    import cmp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_any
);

    int               start;
    logic [N_REQ-1:0] req_rot;

    // Rotate the requests so that bit 0 is the first candidate, then pick the
    // lowest set bit and map it back to an absolute index.
    always_comb begin
        start   = (int'(ptr) + 1) % N_REQ;
        req_rot = N_REQ'({req, req} >> start);
        gnt_any = |req_rot;
        gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_idx = ID_W'((start + i) % N_REQ);
            end
        end
        gnt_oh = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/cmp_frame_sched.sv
// Shares one zero-skip packer among N_REQ producers, one frame per grant.
// After the last word of a frame the packer is flushed, and once it reports
// completion a status record (id, encoded bits, nonzero count) is pulsed out.
module cmp_frame_sched
    import cmp_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WORD_W    = 16,
    parameter  int FRAME_LEN = 64,
    localparam int ID_W      = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ),
    localparam int BITS_W    = clog2(FRAME_LEN * (WORD_W + 1) + 1),
    localparam int CNT_W     = clog2(FRAME_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*WORD_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [WORD_W-1:0]         pk_data,
    output logic                      pk_valid,
    input  logic                      pk_ready,
    output logic                      pk_flush,
    input  logic                      pk_flush_done,
    output logic                      frm_valid,
    output logic [ID_W-1:0]           frm_id,
    output logic [BITS_W-1:0]         frm_bits,
    output logic [CNT_W-1:0]          frm_nz,
    output logic                      busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [N_REQ-1:0]  gnt_oh;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  nz_cnt;
    logic [BITS_W-1:0] bit_acc;

    logic [N_REQ-1:0]  arb_oh;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;
    logic              grant;
    logic              gnt_valid;
    logic [WORD_W-1:0] gnt_word;
    logic              xfer;
    logic              last_word;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign grant     = (state == IDLE) && arb_any;
    assign gnt_word  = req_data[int'(gnt_id) * WORD_W +: WORD_W];
    assign gnt_valid = |(req_valid & gnt_oh);
    assign xfer      = (state == STREAM) && gnt_valid && pk_ready;
    assign last_word = (word_cnt == CNT_W'(FRAME_LEN - 1));
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the per-state handshake outputs; the packer sees the
    // granted lane directly, so pk_valid follows req_valid without waiting on
    // pk_ready.
    always_comb begin
        state_nxt = state;
        pk_valid  = 1'b0;
        pk_data   = '0;
        req_ready = '0;
        pk_flush  = 1'b0;
        frm_valid = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                pk_valid  = gnt_valid;
                pk_data   = gnt_word;
                req_ready = pk_ready ? gnt_oh : '0;
                if (xfer && last_word) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                pk_flush  = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (pk_flush_done) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                frm_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant latch and round-robin pointer; the pointer only advances once a
    // frame has been fully reported, so an aborted frame does not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_id <= '0;
            gnt_oh <= '0;
            rr_ptr <= ID_W'(N_REQ - 1);
        end else if (grant) begin
            gnt_id <= arb_idx;
            gnt_oh <= arb_oh;
        end else if (state == REPORT) begin
            rr_ptr <= gnt_id;
        end
    end

    // Per-frame word, encoded-bit and nonzero counters, cleared at each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            bit_acc  <= '0;
            nz_cnt   <= '0;
        end else if (grant) begin
            word_cnt <= '0;
            bit_acc  <= '0;
            nz_cnt   <= '0;
        end else if (xfer) begin
            word_cnt <= word_cnt + CNT_W'(1);
            bit_acc  <= bit_acc + BITS_W'(enc_bits(64'(gnt_word), WORD_W));
            if (gnt_word != '0) begin
                nz_cnt <= nz_cnt + CNT_W'(1);
            end
        end
    end

    // Status record captured as the flush completes so it is stable during the
    // REPORT pulse and held until the next frame is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_id   <= '0;
            frm_bits <= '0;
            frm_nz   <= '0;
        end else if ((state == WAIT_DONE) && pk_flush_done) begin
            frm_id   <= gnt_id;
            frm_bits <= bit_acc;
            frm_nz   <= nz_cnt;
        end
    end

endmodule

// File: tb/tb_cmp_frame_sched.sv
// Self-checking bench for cmp_frame_sched: a 4-word-frame instance for the
// scheduling scenarios and a 64-word-frame instance for full-length frames.
module tb_cmp_frame_sched;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int FL   = 4;
    localparam int FLB  = 64;
    localparam int IDW  = 2;
    localparam int BW_A = $clog2(FL * (W + 1) + 1);
    localparam int CW_A = $clog2(FL + 1);
    localparam int BW_B = $clog2(FLB * (W + 1) + 1);
    localparam int CW_B = $clog2(FLB + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic [W-1:0]    pk_data;
    logic            pk_valid;
    logic            pk_ready = 1'b0;
    logic            pk_flush;
    logic            pk_flush_done = 1'b0;
    logic            frm_valid;
    logic [IDW-1:0]  frm_id;
    logic [BW_A-1:0] frm_bits;
    logic [CW_A-1:0] frm_nz;
    logic            busy;

    logic [N-1:0]    b_req_valid = '0;
    logic [N*W-1:0]  b_req_data = '0;
    logic [N-1:0]    b_req_ready;
    logic [W-1:0]    b_pk_data;
    logic            b_pk_valid;
    logic            b_pk_ready = 1'b0;
    logic            b_pk_flush;
    logic            b_pk_flush_done = 1'b0;
    logic            b_frm_valid;
    logic [IDW-1:0]  b_frm_id;
    logic [BW_B-1:0] b_frm_bits;
    logic [CW_B-1:0] b_frm_nz;
    logic            b_busy;

    cmp_frame_sched #(.N_REQ(N), .WORD_W(W), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .pk_data(pk_data), .pk_valid(pk_valid),
        .pk_ready(pk_ready), .pk_flush(pk_flush), .pk_flush_done(pk_flush_done),
        .frm_valid(frm_valid), .frm_id(frm_id), .frm_bits(frm_bits),
        .frm_nz(frm_nz), .busy(busy)
    );

    cmp_frame_sched #(.N_REQ(N), .WORD_W(W), .FRAME_LEN(FLB)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .pk_data(b_pk_data), .pk_valid(b_pk_valid),
        .pk_ready(b_pk_ready), .pk_flush(b_pk_flush), .pk_flush_done(b_pk_flush_done),
        .frm_valid(b_frm_valid), .frm_id(b_frm_id), .frm_bits(b_frm_bits),
        .frm_nz(b_frm_nz), .busy(b_busy)
    );

    // Producer word lists and bench state.
    logic [W-1:0] src_mem [N][64];
    int           src_len [N];
    int           src_pos [N];
    logic [N-1:0] en;
    int           rdy_mode, done_delay, done_cnt, cyc, done_cyc, frm_cyc;
    int           flush_cnt, ready_viol, busy_viol, cur_id;
    bit           stray_done, infrm;

    int           obs_id[$], obs_bits[$], obs_nz[$], obs_wid[$];
    logic [W-1:0] obs_word[$];
    int           exp_id[$], exp_bits[$], exp_nz[$], exp_wid[$];
    logic [W-1:0] exp_word[$];

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [W-1:0] rnd_word();
        if ($urandom_range(0, 2) == 0) return '0;
        return W'($urandom_range(1, 65535));
    endfunction

    // Reference: frames are FL-word chunks of each requester's list, served
    // round robin starting after requester N-1.
    task automatic build_expect();
        int rem [N];
        int pos [N];
        int ptr, id, bits, nz;
        bit found;
        logic [W-1:0] w;
        exp_id.delete(); exp_bits.delete(); exp_nz.delete();
        exp_wid.delete(); exp_word.delete();
        ptr = N - 1;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            rem[i] = en[i] ? src_len[i] : 0;
        end
        for (int f = 0; f < 64; f++) begin
            found = 0;
            id = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && rem[(ptr + k) % N] >= FL) begin
                    found = 1;
                    id = (ptr + k) % N;
                end
            end
            if (!found) break;
            bits = 0;
            nz = 0;
            for (int j = 0; j < FL; j++) begin
                w = src_mem[id][pos[id]];
                exp_wid.push_back(id);
                exp_word.push_back(w);
                if (w == 0) bits += 1;
                else begin
                    bits += W + 1;
                    nz++;
                end
                pos[id]++;
                rem[id]--;
            end
            exp_id.push_back(id);
            exp_bits.push_back(bits);
            exp_nz.push_back(nz);
            ptr = id;
        end
    endtask

    task automatic clear_obs();
        obs_id.delete(); obs_bits.delete(); obs_nz.delete();
        obs_wid.delete(); obs_word.delete();
        flush_cnt = 0; ready_viol = 0; busy_viol = 0; infrm = 0;
        done_cnt = 0; stray_done = 0; done_cyc = -100; frm_cyc = -200;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0; req_data = '0; pk_ready = 1'b0; pk_flush_done = 1'b0;
        b_req_valid = '0; b_req_data = '0; b_pk_ready = 1'b0; b_pk_flush_done = 1'b0;
        en = '0; rdy_mode = 0; done_delay = 1;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        clear_obs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of producer/packer behaviour plus observation of the DUT.
    task automatic step();
        int rid;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_pos[i] < src_len[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*W +: W] = src_mem[i][src_pos[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*W +: W] = W'($urandom);
            end
        end
        case (rdy_mode)
            0: pk_ready = 1'b1;
            1: pk_ready = cyc[0];
            default: pk_ready = ($urandom_range(0, 1) == 1);
        endcase
        pk_flush_done = (done_cnt == 1) || stray_done;
        if (done_cnt == 1) done_cyc = cyc;
        if (done_cnt > 0) done_cnt--;
        stray_done = 0;
        #1;
        if (frm_valid) begin
            obs_id.push_back(int'(frm_id));
            obs_bits.push_back(int'(frm_bits));
            obs_nz.push_back(int'(frm_nz));
            frm_cyc = cyc;
            if (!busy) busy_viol++;
            infrm = 0;
        end else if (infrm && !busy) begin
            busy_viol++;
        end
        if ($countones(req_ready) > 1) ready_viol++;
        rid = -1;
        for (int i = 0; i < N; i++) if (req_ready[i] && rid < 0) rid = i;
        if (rid >= 0 && infrm && rid != cur_id) ready_viol++;
        if (pk_valid && pk_ready) begin
            if (rid < 0) ready_viol++;
            else begin
                obs_wid.push_back(rid);
                obs_word.push_back(pk_data);
                if (!infrm) begin
                    infrm = 1;
                    cur_id = rid;
                end
            end
        end
        if (pk_flush) begin
            flush_cnt++;
            done_cnt = done_delay;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) src_pos[i]++;
        cyc++;
    endtask

    task automatic run(input int nfrm, input int budget);
        int k;
        k = 0;
        while (obs_id.size() < nfrm && k < budget) begin
            step();
            k++;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1; req_data = {N{16'hA5A5}}; pk_ready = 1'b1; pk_flush_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (pk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pk_valid: got %b want 0", pk_valid); end
        n_chk++; if (pk_flush !== 1'b0) begin n_fail++; $display("FAIL reset_pk_flush: got %b want 0", pk_flush); end
        n_chk++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frm_valid: got %b want 0", frm_valid); end
        n_chk++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_chk++; if (pk_data !== 16'h0) begin n_fail++; $display("FAIL reset_pk_data: got %h want 0", pk_data); end
        n_chk++; if ({frm_id, frm_bits, frm_nz} !== '0) begin
            n_fail++; $display("FAIL reset_frm_fields: got id=%0d bits=%0d nz=%0d want 0", frm_id, frm_bits, frm_nz);
        end
        do_reset();
        repeat (4) step();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
    endtask

    task automatic load_basic(input int r);
        src_mem[r][0] = 16'h0000; src_mem[r][1] = 16'h1234;
        src_mem[r][2] = 16'h0000; src_mem[r][3] = 16'hFFFF;
        src_len[r] = 4; src_pos[r] = 0;
    endtask

    task automatic test_frame_counters();
        do_reset();
        load_basic(0);
        en = 4'b0001;
        run(1, 60);
        n_chk++; if (obs_id.size() !== 1) begin n_fail++; $display("FAIL fc_frames: got %0d want 1", obs_id.size()); end
        if (obs_id.size() > 0) begin
            n_chk++; if (obs_id[0] !== 0 || obs_bits[0] !== 36 || obs_nz[0] !== 2) begin
                n_fail++; $display("FAIL fc_record: got id=%0d bits=%0d nz=%0d want 0/36/2", obs_id[0], obs_bits[0], obs_nz[0]);
            end
        end
        n_chk++; if (obs_word.size() !== 4) begin n_fail++; $display("FAIL fc_xfers: got %0d want 4", obs_word.size()); end
        for (int i = 0; i < obs_word.size() && i < 4; i++) begin
            n_chk++; if (obs_word[i] !== src_mem[0][i]) begin
                n_fail++; $display("FAIL fc_word%0d: got %h want %h", i, obs_word[i], src_mem[0][i]);
            end
        end
        n_chk++; if (flush_cnt !== 1) begin n_fail++; $display("FAIL fc_flush_pulses: got %0d want 1", flush_cnt); end
        n_chk++; if (ready_viol !== 0 || busy_viol !== 0) begin
            n_fail++; $display("FAIL fc_handshake: got ready_viol=%0d busy_viol=%0d want 0", ready_viol, busy_viol);
        end
        repeat (5) step();
        n_chk++; if (frm_bits !== 7'd36 || frm_nz !== 3'd2 || frm_valid !== 1'b0) begin
            n_fail++; $display("FAIL fc_hold: got bits=%0d nz=%0d valid=%b want 36/2/0", frm_bits, frm_nz, frm_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 4'b1111;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < 2 * FL; j++) src_mem[r][j] = rnd_word();
            src_len[r] = 2 * FL;
        end
        build_expect();
        run(8, 400);
        n_chk++; if (obs_id.size() !== 8) begin n_fail++; $display("FAIL rr_frames: got %0d want 8", obs_id.size()); end
        for (int f = 0; f < obs_id.size() && f < exp_id.size(); f++) begin
            n_chk++; if (obs_id[f] !== (f % N)) begin
                n_fail++; $display("FAIL rr_order%0d: got id=%0d want %0d", f, obs_id[f], f % N);
            end
            n_chk++; if (obs_bits[f] !== exp_bits[f] || obs_nz[f] !== exp_nz[f]) begin
                n_fail++; $display("FAIL rr_counts%0d: got bits=%0d nz=%0d want %0d/%0d", f, obs_bits[f], obs_nz[f], exp_bits[f], exp_nz[f]);
            end
        end
        n_chk++; if (obs_word.size() !== exp_word.size()) begin
            n_fail++; $display("FAIL rr_xfers: got %0d want %0d", obs_word.size(), exp_word.size());
        end
        for (int i = 0; i < obs_word.size() && i < exp_word.size(); i++) begin
            n_chk++; if (obs_word[i] !== exp_word[i] || obs_wid[i] !== exp_wid[i]) begin
                n_fail++; $display("FAIL rr_word%0d: got r%0d:%h want r%0d:%h", i, obs_wid[i], obs_word[i], exp_wid[i], exp_word[i]);
            end
        end
        n_chk++; if (ready_viol !== 0) begin n_fail++; $display("FAIL rr_ready_nongranted: got %0d events want 0", ready_viol); end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_basic(0);
        en = 4'b0001;
        rdy_mode = 1;
        run(1, 80);
        n_chk++; if (obs_word.size() !== 4) begin n_fail++; $display("FAIL bp_xfers: got %0d want 4", obs_word.size()); end
        for (int i = 0; i < obs_word.size() && i < 4; i++) begin
            n_chk++; if (obs_word[i] !== src_mem[0][i]) begin
                n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, obs_word[i], src_mem[0][i]);
            end
        end
        n_chk++; if (obs_id.size() !== 1 || (obs_id.size() > 0 && (obs_bits[0] !== 36 || obs_nz[0] !== 2))) begin
            n_fail++; $display("FAIL bp_record: got frames=%0d want one frame with bits 36 nz 2", obs_id.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 4'($urandom_range(1, 15));
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < 3 * FL; j++) src_mem[r][j] = rnd_word();
            src_len[r] = FL * $urandom_range(1, 3);
        end
        rdy_mode = 2;
        done_delay = $urandom_range(1, 4);
        build_expect();
        run(exp_id.size(), 1500);
        n_chk++; if (obs_id.size() !== exp_id.size()) begin
            n_fail++; $display("FAIL b2b_frames: got %0d want %0d", obs_id.size(), exp_id.size());
        end
        for (int f = 0; f < obs_id.size() && f < exp_id.size(); f++) begin
            n_chk++; if (obs_id[f] !== exp_id[f] || obs_bits[f] !== exp_bits[f] || obs_nz[f] !== exp_nz[f]) begin
                n_fail++; $display("FAIL b2b_frame%0d: got %0d/%0d/%0d want %0d/%0d/%0d", f, obs_id[f], obs_bits[f], obs_nz[f], exp_id[f], exp_bits[f], exp_nz[f]);
            end
        end
        n_chk++; if (obs_word != exp_word || obs_wid != exp_wid) begin
            n_fail++; $display("FAIL b2b_words: got %0d transfers want %0d in model order", obs_word.size(), exp_word.size());
        end
        n_chk++; if (ready_viol !== 0 || busy_viol !== 0) begin
            n_fail++; $display("FAIL b2b_handshake: got ready_viol=%0d busy_viol=%0d want 0", ready_viol, busy_viol);
        end
    endtask

    task automatic test_flush_wait();
        int nbefore;
        do_reset();
        en = 4'b0010;
        for (int j = 0; j < FL; j++) src_mem[1][j] = rnd_word();
        src_len[1] = FL;
        done_delay = 5;
        build_expect();
        run(1, 80);
        n_chk++; if (obs_id.size() !== 1 || (obs_id.size() > 0 && (obs_id[0] !== 1 || obs_bits[0] !== exp_bits[0] || obs_nz[0] !== exp_nz[0]))) begin
            n_fail++; $display("FAIL fw_record: got frames=%0d want one frame id 1 bits %0d nz %0d", obs_id.size(), exp_bits[0], exp_nz[0]);
        end
        n_chk++; if (frm_cyc - done_cyc !== 1) begin
            n_fail++; $display("FAIL fw_latency: got %0d cycles from done to frm_valid want 1", frm_cyc - done_cyc);
        end
        n_chk++; if (busy_viol !== 0) begin n_fail++; $display("FAIL fw_busy: got %0d low cycles in frame want 0", busy_viol); end
        nbefore = obs_id.size();
        stray_done = 1;
        repeat (8) step();
        n_chk++; if (obs_id.size() !== nbefore || busy !== 1'b0) begin
            n_fail++; $display("FAIL fw_stray_done: got frames=%0d busy=%b want %0d/0", obs_id.size(), busy, nbefore);
        end
    endtask

    task automatic test_zero_nonzero();
        logic [W-1:0] bw [FLB];
        int pos, acc, got, g_bits, g_nz, g_id, m_bits;
        bit done_next, acc_now;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            m_bits = 0;
            for (int j = 0; j < FLB; j++) begin
                bw[j] = (p == 0) ? '0 : W'($urandom_range(1, 65535));
                m_bits += (bw[j] == 0) ? 1 : W + 1;
            end
            pos = 0; acc = 0; got = 0; done_next = 0;
            g_bits = -1; g_nz = -1; g_id = -1;
            for (int c = 0; c < 400 && got == 0; c++) begin
                @(negedge clk);
                b_req_data = '0;
                b_req_valid = {3'b000, (pos < FLB)};
                if (pos < FLB) b_req_data[W-1:0] = bw[pos];
                b_pk_ready = 1'b1;
                b_pk_flush_done = done_next;
                done_next = 0;
                #1;
                if (b_pk_flush) done_next = 1;
                if (b_frm_valid) begin
                    got = 1; g_bits = int'(b_frm_bits); g_nz = int'(b_frm_nz); g_id = int'(b_frm_id);
                end
                acc_now = b_req_ready[0] && b_req_valid[0];
                @(posedge clk);
                if (acc_now) begin pos++; acc++; end
            end
            n_chk++; if (got !== 1 || acc !== FLB || g_id !== 0) begin
                n_fail++; $display("FAIL zn%0d_frame: got report=%0d words=%0d id=%0d want 1/%0d/0", p, got, acc, g_id, FLB);
            end
            n_chk++; if (g_bits !== ((p == 0) ? 64 : 1088) || g_bits !== m_bits) begin
                n_fail++; $display("FAIL zn%0d_bits: got %0d want %0d", p, g_bits, m_bits);
            end
            n_chk++; if (g_nz !== ((p == 0) ? 0 : 64)) begin
                n_fail++; $display("FAIL zn%0d_nz: got %0d want %0d", p, g_nz, (p == 0) ? 0 : 64);
            end
        end
        b_req_valid = '0;
    endtask

    task automatic test_async_reset();
        int k;
        do_reset();
        en = 4'b0001;
        for (int j = 0; j < FL; j++) src_mem[0][j] = rnd_word();
        src_len[0] = FL;
        k = 0;
        while (obs_word.size() < 2 && k < 40) begin
            step();
            k++;
        end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (obs_word.size() !== 2) begin n_fail++; $display("FAIL ar_pre_words: got %0d want 2", obs_word.size()); end
        n_chk++; if (busy !== 1'b0 || pk_valid !== 1'b0 || req_ready !== 4'b0 || frm_valid !== 1'b0) begin
            n_fail++; $display("FAIL ar_async_clear: got busy=%b pk_valid=%b req_ready=%b frm_valid=%b want 0", busy, pk_valid, req_ready, frm_valid);
        end
        repeat (2) @(negedge clk);
        clear_obs();
        en = 4'b0101;
        for (int j = 0; j < FL; j++) begin
            src_mem[0][j] = rnd_word();
            src_mem[2][j] = rnd_word();
        end
        src_len[0] = FL; src_pos[0] = 0;
        src_len[2] = FL; src_pos[2] = 0;
        rst = 1'b0;
        build_expect();
        run(2, 200);
        n_chk++; if (obs_id.size() !== 2) begin n_fail++; $display("FAIL ar_frames: got %0d want 2", obs_id.size()); end
        n_chk++; if (obs_id.size() > 0 && obs_id[0] !== 0) begin
            n_fail++; $display("FAIL ar_first_id: got %0d want 0", obs_id[0]);
        end
        for (int f = 0; f < obs_id.size() && f < exp_id.size(); f++) begin
            n_chk++; if (obs_id[f] !== exp_id[f] || obs_bits[f] !== exp_bits[f] || obs_nz[f] !== exp_nz[f]) begin
                n_fail++; $display("FAIL ar_frame%0d: got %0d/%0d/%0d want %0d/%0d/%0d", f, obs_id[f], obs_bits[f], obs_nz[f], exp_id[f], exp_bits[f], exp_nz[f]);
            end
        end
        n_chk++; if (obs_word != exp_word) begin
            n_fail++; $display("FAIL ar_words: got %0d transfers want %0d in model order", obs_word.size(), exp_word.size());
        end
    endtask

    initial begin
        cyc = 0;
        en = '0;
        rdy_mode = 0;
        done_delay = 1;
        cur_id = 0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        clear_obs();
        test_reset();
        test_frame_counters();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_flush_wait();
        test_zero_nonzero();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
